// File: rtl/sr_mem_arbiter.sv
// sr_mem_arbiter
// ---------------------------------------------------------------------------
// Shares one valid/ready memory request channel and one valid/ready response
// channel between N_REQ requesters. It is meant to sit between several CPU
// cores and a single downstream memory port such as an AXI adapter.
//
// Arbitration is round-robin and only one transaction is outstanding at a
// time. Each request, read or write, gets exactly one response.
// A transaction passes through three states:
//   IDLE : choose the next requester, starting the search at ptr.
//   REQ  : the chosen requester's handshake is routed to the downstream port.
//   RESP : the downstream response is routed back to that requester.
// Only the control state (state, gnt, ptr) is registered. Payload and
// handshake paths are combinational, so nothing is buffered.
//
// Ports
//   clk, rst          clock and synchronous active-high reset
//   req_wr_i          per-requester write flag (1 = write, 0 = read)
//   req_addr_i        per-requester address; requester k is at
//                     [k*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata_i       per-requester write data, sliced the same way
//   req_valid_i       per-requester request valid
//   req_ready_o       per-requester request accepted
//   resp_valid_o      per-requester response valid
//   resp_ready_i      per-requester ready for response
//   resp_rdata_o      response data shared by all requesters; qualified
//                     by resp_valid_o[k]
//   mem_*             downstream request/response channel
//
// Optional feature: define SR_MEM_ARB_STATS_EN to add these ports.
//   stats_clr_i       synchronous clear of all counters; wins over increment
//   gnt_cnt_o         N_REQ saturating 16-bit counters of completed responses,
//                     one per requester; requester k is at [k*16 +: 16]
// ---------------------------------------------------------------------------
module sr_mem_arbiter #(
  parameter int N_REQ      = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_wr_i,
  input  logic [N_REQ*ADDR_WIDTH-1:0]  req_addr_i,
  input  logic [N_REQ*DATA_WIDTH-1:0]  req_wdata_i,
  input  logic [N_REQ-1:0]             req_valid_i,
  output logic [N_REQ-1:0]             req_ready_o,
  output logic [N_REQ-1:0]             resp_valid_o,
  input  logic [N_REQ-1:0]             resp_ready_i,
  output logic [DATA_WIDTH-1:0]        resp_rdata_o,
  output logic                         mem_wr_o,
  output logic [ADDR_WIDTH-1:0]        mem_addr_o,
  output logic [DATA_WIDTH-1:0]        mem_wdata_o,
  output logic                         mem_req_valid_o,
  input  logic                         mem_req_ready_i,
  input  logic                         mem_resp_valid_i,
  output logic                         mem_resp_ready_o,
  input  logic [DATA_WIDTH-1:0]        mem_rdata_i
`ifdef SR_MEM_ARB_STATS_EN
  ,
  input  logic                         stats_clr_i,
  output logic [N_REQ*16-1:0]          gnt_cnt_o
`endif
);

  localparam int GW = $clog2(N_REQ);
  localparam logic [GW-1:0] LAST_IDX = GW'(N_REQ - 1);
  localparam logic [GW:0]   N_REQ_W  = (GW+1)'(N_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] gnt_q, gnt_d;
  logic [GW-1:0] ptr_q, ptr_d;

  // Signals of the currently granted requester.
  logic                  sel_valid;
  logic                  sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_resp_ready;
  logic [N_REQ-1:0]      gnt_onehot;

  // Round-robin search result.
  logic                  arb_found;
  logic [GW-1:0]         arb_winner;
  logic [GW:0]           arb_cand;

  logic                  resp_hs;

  // --- Granted-requester select -------------------------------------------
  always_comb begin
    sel_valid      = 1'b0;
    sel_wr         = 1'b0;
    sel_addr       = '0;
    sel_wdata      = '0;
    sel_resp_ready = 1'b0;
    gnt_onehot     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt_q == GW'(k)) begin
        sel_valid      = req_valid_i[k];
        sel_wr         = req_wr_i[k];
        sel_addr       = req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata      = req_wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
        sel_resp_ready = resp_ready_i[k];
        gnt_onehot[k]  = 1'b1;
      end
    end
  end

  // --- Round-robin search -------------------------------------------------
  // Candidates are visited in the order ptr, ptr+1, ... modulo N_REQ. One
  // extra bit of width keeps ptr+i from overflowing before the wrap, which
  // matters when N_REQ is not a power of two.
  always_comb begin
    arb_found  = 1'b0;
    arb_winner = '0;
    arb_cand   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      arb_cand = {1'b0, ptr_q} + (GW+1)'(i);
      if (arb_cand >= N_REQ_W) begin
        arb_cand = arb_cand - N_REQ_W;
      end
      if (!arb_found && req_valid_i[arb_cand[GW-1:0]]) begin
        arb_found  = 1'b1;
        arb_winner = arb_cand[GW-1:0];
      end
    end
  end

  assign resp_hs = (state_q == RESP) && mem_resp_valid_i && sel_resp_ready;

  // --- Next state and outputs ---------------------------------------------
  always_comb begin
    state_d          = state_q;
    gnt_d            = gnt_q;
    ptr_d            = ptr_q;
    req_ready_o      = '0;
    resp_valid_o     = '0;
    resp_rdata_o     = '0;
    mem_wr_o         = 1'b0;
    mem_addr_o       = '0;
    mem_wdata_o      = '0;
    mem_req_valid_o  = 1'b0;
    mem_resp_ready_o = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb_found) begin
          gnt_d   = arb_winner;
          state_d = REQ;
        end
      end

      REQ: begin
        mem_req_valid_o = sel_valid;
        mem_wr_o        = sel_wr;
        mem_addr_o      = sel_addr;
        mem_wdata_o     = sel_wdata;
        req_ready_o     = gnt_onehot & {N_REQ{mem_req_ready_i}};
        // A requester that drops valid before acceptance breaks the
        // protocol. Give up the grant without advancing ptr, so the same
        // requester keeps priority if it asks again.
        if (!sel_valid) begin
          state_d = IDLE;
        end else if (mem_req_ready_i) begin
          state_d = RESP;
        end
      end

      RESP: begin
        resp_valid_o     = gnt_onehot & {N_REQ{mem_resp_valid_i}};
        mem_resp_ready_o = sel_resp_ready;
        resp_rdata_o     = mem_rdata_i;
        if (resp_hs) begin
          state_d = IDLE;
          ptr_d   = (gnt_q == LAST_IDX) ? '0 : gnt_q + GW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs stay quiet for the whole reset cycle, even if reset arrives
    // in the middle of a transaction.
    if (rst) begin
      req_ready_o      = '0;
      resp_valid_o     = '0;
      resp_rdata_o     = '0;
      mem_wr_o         = 1'b0;
      mem_addr_o       = '0;
      mem_wdata_o      = '0;
      mem_req_valid_o  = 1'b0;
      mem_resp_ready_o = 1'b0;
    end
  end

  // --- Control registers --------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef SR_MEM_ARB_STATS_EN
  // --- Completion counters ------------------------------------------------
  logic [N_REQ-1:0][15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (stats_clr_i) begin
      cnt_d = '0;
    end else if (resp_hs) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (gnt_q == GW'(k) && cnt_q[k] != 16'hFFFF) begin
          cnt_d[k] = cnt_q[k] + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign gnt_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_sr_mem_arbiter.sv
// tb_sr_mem_arbiter
// Directed bench for sr_mem_arbiter using N_REQ=4, ADDR_WIDTH=16 and
// DATA_WIDTH=32. Inputs are driven on the falling edge. Outputs are sampled
// 1ns later, away from the rising edge where the state registers update.
module tb_sr_mem_arbiter;
  localparam int N_REQ = 4;
  localparam int AW    = 16;
  localparam int DW    = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N_REQ-1:0]     req_wr_i;
  logic [N_REQ*AW-1:0]  req_addr_i;
  logic [N_REQ*DW-1:0]  req_wdata_i;
  logic [N_REQ-1:0]     req_valid_i;
  logic [N_REQ-1:0]     req_ready_o;
  logic [N_REQ-1:0]     resp_valid_o;
  logic [N_REQ-1:0]     resp_ready_i;
  logic [DW-1:0]        resp_rdata_o;
  logic                 mem_wr_o;
  logic [AW-1:0]        mem_addr_o;
  logic [DW-1:0]        mem_wdata_o;
  logic                 mem_req_valid_o;
  logic                 mem_req_ready_i;
  logic                 mem_resp_valid_i;
  logic                 mem_resp_ready_o;
  logic [DW-1:0]        mem_rdata_i;
`ifdef SR_MEM_ARB_STATS_EN
  logic                 stats_clr_i;
  logic [N_REQ*16-1:0]  gnt_cnt_o;
`endif

  int vecs = 0;
  int errs = 0;

  // All outputs packed together, for the checks that expect every output
  // to be zero.
  logic [4+4+1+1+1+AW+DW+DW-1:0] all_out;
  assign all_out = {req_ready_o, resp_valid_o, mem_req_valid_o, mem_resp_ready_o,
                    mem_wr_o, mem_addr_o, mem_wdata_o, resp_rdata_o};

  always #5 clk = ~clk;

  sr_mem_arbiter #(
    .N_REQ(N_REQ),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_wr_i(req_wr_i),
    .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready_i),
    .resp_rdata_o(resp_rdata_o),
    .mem_wr_o(mem_wr_o),
    .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_req_valid_o(mem_req_valid_o),
    .mem_req_ready_i(mem_req_ready_i),
    .mem_resp_valid_i(mem_resp_valid_i),
    .mem_resp_ready_o(mem_resp_ready_o),
    .mem_rdata_i(mem_rdata_i)
`ifdef SR_MEM_ARB_STATS_EN
    ,
    .stats_clr_i(stats_clr_i),
    .gnt_cnt_o(gnt_cnt_o)
`endif
  );

  task automatic set_req(input int k, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_wr_i[k]          = wr;
    req_addr_i[k*AW +: AW] = a;
    req_wdata_i[k*DW +: DW] = d;
  endtask

  task automatic idle_inputs();
    req_wr_i         = '0;
    req_addr_i       = '0;
    req_wdata_i      = '0;
    req_valid_i      = '0;
    resp_ready_i     = '0;
    mem_req_ready_i  = 1'b0;
    mem_resp_valid_i = 1'b0;
    mem_rdata_i      = '0;
`ifdef SR_MEM_ARB_STATS_EN
    stats_clr_i      = 1'b0;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    // Hold reset with every input busy; the outputs must stay silent.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      rst              = 1'b1;
      req_valid_i      = '1;
      req_wr_i         = '1;
      resp_ready_i     = '1;
      mem_req_ready_i  = 1'b1;
      mem_resp_valid_i = 1'b1;
      mem_rdata_i      = 32'hFFFF_FFFF;
      #1;
      vecs++;
      if (all_out !== '0) begin
        errs++;
        $display("FAIL reset_during[%0d]: outputs=%h, want 0", c, all_out);
      end
    end
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    #1;
    vecs++;
    if (all_out !== '0 || dut.ptr_q !== 2'd0 || dut.gnt_q !== 2'd0) begin
      errs++;
      $display("FAIL reset_after: outputs=%h ptr=%0d gnt=%0d, want 0/0/0",
               all_out, dut.ptr_q, dut.gnt_q);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    @(negedge clk);
    set_req(2, 1'b0, 16'h0040, 32'h0);
    set_req(1, 1'b1, 16'h9999, 32'h1111_1111);
    req_valid_i     = 4'b0100;
    mem_req_ready_i = 1'b1;
    resp_ready_i    = 4'b1111;
    #1;
    vecs++;
    if (mem_req_valid_o !== 1'b0 || req_ready_o !== 4'b0000) begin
      errs++;
      $display("FAIL single_idle: mem_req_valid=%b req_ready=%b, want 0/0000",
               mem_req_valid_o, req_ready_o);
    end
    @(negedge clk);
    #1;
    vecs++;
    if (mem_req_valid_o !== 1'b1 || mem_addr_o !== 16'h0040 || mem_wr_o !== 1'b0 ||
        req_ready_o !== 4'b0100) begin
      errs++;
      $display("FAIL single_req: valid=%b addr=%h wr=%b ready=%b, want 1/0040/0/0100",
               mem_req_valid_o, mem_addr_o, mem_wr_o, req_ready_o);
    end
    @(negedge clk);
    req_valid_i      = 4'b0000;
    mem_resp_valid_i = 1'b1;
    mem_rdata_i      = 32'hDEAD_BEEF;
    #1;
    vecs++;
    if (resp_valid_o !== 4'b0100 || resp_rdata_o !== 32'hDEAD_BEEF ||
        mem_resp_ready_o !== 1'b1 || mem_req_valid_o !== 1'b0) begin
      errs++;
      $display("FAIL single_resp: resp_valid=%b rdata=%h mem_resp_ready=%b, want 0100/deadbeef/1",
               resp_valid_o, resp_rdata_o, mem_resp_ready_o);
    end
    @(negedge clk);
    mem_resp_valid_i = 1'b0;
    #1;
    vecs++;
    if (dut.ptr_q !== 2'd3 || resp_valid_o !== 4'b0000 || mem_resp_ready_o !== 1'b0) begin
      errs++;
      $display("FAIL single_ptr: ptr=%0d resp_valid=%b, want 3/0000",
               dut.ptr_q, resp_valid_o);
    end
  endtask

  task automatic test_round_robin();
    int            cnt [N_REQ];
    int            nw;
    int            exp_k;
    logic [3:0]    exp_oh;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_d;
    do_reset();
    for (int k = 0; k < N_REQ; k++) cnt[k] = 0;
    nw = 0;
    for (int cyc = 0; cyc < 80 && nw < 12; cyc++) begin
      @(negedge clk);
      mem_req_ready_i  = 1'b1;
      mem_resp_valid_i = 1'b1;
      resp_ready_i     = 4'b1111;
      for (int k = 0; k < N_REQ; k++) begin
        req_valid_i[k] = (cnt[k] < 3);
        set_req(k, 1'b1, AW'(32'h1000 * k + cnt[k]), DW'(32'hC0DE_0000 + 16 * k + cnt[k]));
      end
      #1;
      if (mem_req_valid_o && mem_req_ready_i) begin
        exp_k  = nw % 4;
        exp_oh = 4'(1 << exp_k);
        exp_a  = AW'(32'h1000 * exp_k + nw / 4);
        exp_d  = DW'(32'hC0DE_0000 + 16 * exp_k + nw / 4);
        vecs++;
        if (req_ready_o !== exp_oh || mem_wr_o !== 1'b1 || mem_addr_o !== exp_a ||
            mem_wdata_o !== exp_d) begin
          errs++;
          $display("FAIL rr_write[%0d]: ready=%b addr=%h wdata=%h wr=%b, want %b/%h/%h/1",
                   nw, req_ready_o, mem_addr_o, mem_wdata_o, mem_wr_o, exp_oh, exp_a, exp_d);
        end
        for (int k = 0; k < N_REQ; k++) if (req_ready_o[k]) cnt[k]++;
        nw++;
      end
    end
    vecs++;
    if (nw != 12) begin
      errs++;
      $display("FAIL rr_count: writes=%0d, want 12", nw);
    end
    @(negedge clk);
    req_valid_i = '0;
    @(negedge clk);
    mem_resp_valid_i = 1'b0;
    #1;
    vecs++;
    if (dut.ptr_q !== 2'd0) begin
      errs++;
      $display("FAIL rr_ptr_wrap: ptr=%0d, want 0", dut.ptr_q);
    end
  endtask

  task automatic test_backpressure();
    int req_hs  = 0;
    int resp_hs = 0;
    // ptr is 0 here; requester 1 wins, and requester 3 stays pending throughout.
    @(negedge clk);
    idle_inputs();
    set_req(1, 1'b1, 16'h0BAD, 32'hFEED_F00D);
    set_req(3, 1'b0, 16'h3333, 32'h0);
    req_valid_i  = 4'b1010;
    resp_ready_i = 4'b1101;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      mem_req_ready_i = (c == 5);
      #1;
      if (mem_req_valid_o && mem_req_ready_i) req_hs++;
      vecs++;
      if (mem_req_valid_o !== 1'b1 || mem_addr_o !== 16'h0BAD || mem_wdata_o !== 32'hFEED_F00D ||
          mem_wr_o !== 1'b1 || req_ready_o !== ((c == 5) ? 4'b0010 : 4'b0000)) begin
        errs++;
        $display("FAIL bp_req[%0d]: valid=%b addr=%h wdata=%h wr=%b ready=%b, want 1/0bad/feedf00d/1",
                 c, mem_req_valid_o, mem_addr_o, mem_wdata_o, mem_wr_o, req_ready_o);
      end
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      req_valid_i      = 4'b1000;
      mem_resp_valid_i = (c >= 7);
      mem_rdata_i      = 32'h600D_CAFE;
      resp_ready_i     = (c == 9) ? 4'b1111 : 4'b1101;
      #1;
      if (mem_req_valid_o && mem_req_ready_i) req_hs++;
      if (mem_resp_valid_i && mem_resp_ready_o) resp_hs++;
      vecs++;
      if (mem_req_valid_o !== 1'b0 || req_ready_o !== 4'b0000 ||
          resp_valid_o !== ((c >= 7) ? 4'b0010 : 4'b0000) ||
          mem_resp_ready_o !== (c == 9) || resp_rdata_o !== 32'h600D_CAFE) begin
        errs++;
        $display("FAIL bp_resp[%0d]: mem_req_valid=%b resp_valid=%b mem_resp_ready=%b rdata=%h",
                 c, mem_req_valid_o, resp_valid_o, mem_resp_ready_o, resp_rdata_o);
      end
    end
    @(negedge clk);
    req_valid_i      = 4'b0000;
    mem_resp_valid_i = 1'b0;
    #1;
    vecs++;
    if (req_hs != 1 || resp_hs != 1 || dut.ptr_q !== 2'd2) begin
      errs++;
      $display("FAIL bp_handshakes: req_hs=%0d resp_hs=%0d ptr=%0d, want 1/1/2",
               req_hs, resp_hs, dut.ptr_q);
    end
  endtask

  task automatic test_valid_drop();
    // ptr is 2. Requester 2 withdraws its request before acceptance.
    @(negedge clk);
    idle_inputs();
    set_req(2, 1'b1, 16'h2222, 32'h2);
    set_req(0, 1'b1, 16'h0000, 32'h0);
    req_valid_i = 4'b0100;
    @(negedge clk);
    #1;
    vecs++;
    if (mem_req_valid_o !== 1'b1 || mem_addr_o !== 16'h2222 || req_ready_o !== 4'b0000) begin
      errs++;
      $display("FAIL drop_req: valid=%b addr=%h ready=%b, want 1/2222/0000",
               mem_req_valid_o, mem_addr_o, req_ready_o);
    end
    @(negedge clk);
    req_valid_i = 4'b0000;
    #1;
    vecs++;
    if (mem_req_valid_o !== 1'b0 || req_ready_o !== 4'b0000) begin
      errs++;
      $display("FAIL drop_valid: valid=%b ready=%b, want 0/0000", mem_req_valid_o, req_ready_o);
    end
    @(negedge clk);
    #1;
    vecs++;
    if (dut.ptr_q !== 2'd2 || all_out !== '0) begin
      errs++;
      $display("FAIL drop_ptr: ptr=%0d outputs=%h, want 2/0", dut.ptr_q, all_out);
    end
    // With ptr still 2, requester 2 must win against requester 0.
    req_valid_i      = 4'b0101;
    mem_req_ready_i  = 1'b1;
    resp_ready_i     = 4'b1111;
    mem_resp_valid_i = 1'b1;
    @(negedge clk);
    #1;
    vecs++;
    if (req_ready_o !== 4'b0100) begin
      errs++;
      $display("FAIL drop_regrant: ready=%b, want 0100", req_ready_o);
    end
    @(negedge clk);
    req_valid_i = 4'b0000;
    @(negedge clk);
    mem_resp_valid_i = 1'b0;
    #1;
    vecs++;
    if (dut.ptr_q !== 2'd3) begin
      errs++;
      $display("FAIL drop_ptr_after: ptr=%0d, want 3", dut.ptr_q);
    end
  endtask

  task automatic test_wrap_priority();
    logic [3:0] pending;
    int         seq_n;
    int         exp_k;
    logic [3:0] exp_oh;
    vecs++;
    if (dut.ptr_q !== 2'd3) begin
      errs++;
      $display("FAIL wrap_start_ptr: ptr=%0d, want 3", dut.ptr_q);
    end
    pending = 4'b1001;
    seq_n   = 0;
    set_req(3, 1'b1, 16'h3003, 32'h3);
    set_req(0, 1'b1, 16'h3000, 32'h0);
    for (int cyc = 0; cyc < 20 && seq_n < 2; cyc++) begin
      @(negedge clk);
      req_valid_i      = pending;
      mem_req_ready_i  = 1'b1;
      mem_resp_valid_i = 1'b1;
      resp_ready_i     = 4'b1111;
      #1;
      if (mem_req_valid_o && mem_req_ready_i) begin
        exp_k  = (seq_n == 0) ? 3 : 0;
        exp_oh = 4'(1 << exp_k);
        vecs++;
        if (req_ready_o !== exp_oh || mem_addr_o !== AW'(32'h3000 + exp_k)) begin
          errs++;
          $display("FAIL wrap_grant[%0d]: ready=%b addr=%h, want %b/%h",
                   seq_n, req_ready_o, mem_addr_o, exp_oh, AW'(32'h3000 + exp_k));
        end
        pending = pending & ~req_ready_o;
        seq_n++;
      end
    end
    vecs++;
    if (seq_n != 2) begin
      errs++;
      $display("FAIL wrap_count: grants=%0d, want 2", seq_n);
    end
    @(negedge clk);
    req_valid_i = 4'b0000;
    @(negedge clk);
    mem_resp_valid_i = 1'b0;
    #1;
    vecs++;
    if (dut.ptr_q !== 2'd1) begin
      errs++;
      $display("FAIL wrap_ptr_after: ptr=%0d, want 1", dut.ptr_q);
    end
  endtask

  task automatic test_reset_mid_resp();
    @(negedge clk);
    idle_inputs();
    set_req(0, 1'b0, 16'h0A0A, 32'h0);
    req_valid_i     = 4'b0001;
    mem_req_ready_i = 1'b1;
    resp_ready_i    = 4'b1111;
    @(negedge clk);
    #1;
    vecs++;
    if (mem_req_valid_o !== 1'b1 || req_ready_o !== 4'b0001) begin
      errs++;
      $display("FAIL rmr_req: valid=%b ready=%b, want 1/0001", mem_req_valid_o, req_ready_o);
    end
    @(negedge clk);
    req_valid_i = 4'b0000;
    #1;
    vecs++;
    if (mem_resp_ready_o !== 1'b1 || resp_valid_o !== 4'b0000) begin
      errs++;
      $display("FAIL rmr_in_resp: mem_resp_ready=%b resp_valid=%b, want 1/0000",
               mem_resp_ready_o, resp_valid_o);
    end
    @(negedge clk);
    rst              = 1'b1;
    mem_resp_valid_i = 1'b1;
    mem_rdata_i      = 32'hBADB_AD00;
    #1;
    vecs++;
    if (all_out !== '0) begin
      errs++;
      $display("FAIL rmr_during: outputs=%h, want 0", all_out);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vecs++;
    if (all_out !== '0 || dut.ptr_q !== 2'd0) begin
      errs++;
      $display("FAIL rmr_after: outputs=%h ptr=%0d, want 0/0", all_out, dut.ptr_q);
    end
    @(negedge clk);
    mem_resp_valid_i = 1'b0;
    set_req(1, 1'b0, 16'h1111, 32'h0);
    req_valid_i = 4'b0010;
    @(negedge clk);
    #1;
    vecs++;
    if (mem_req_valid_o !== 1'b1 || mem_addr_o !== 16'h1111 || mem_wr_o !== 1'b0 ||
        req_ready_o !== 4'b0010) begin
      errs++;
      $display("FAIL rmr_new_req: valid=%b addr=%h wr=%b ready=%b, want 1/1111/0/0010",
               mem_req_valid_o, mem_addr_o, mem_wr_o, req_ready_o);
    end
    @(negedge clk);
    req_valid_i      = 4'b0000;
    mem_resp_valid_i = 1'b1;
    mem_rdata_i      = 32'h1234_5678;
    #1;
    vecs++;
    if (resp_valid_o !== 4'b0010 || resp_rdata_o !== 32'h1234_5678) begin
      errs++;
      $display("FAIL rmr_new_resp: resp_valid=%b rdata=%h, want 0010/12345678",
               resp_valid_o, resp_rdata_o);
    end
    @(negedge clk);
    mem_resp_valid_i = 1'b0;
    #1;
    vecs++;
    if (dut.ptr_q !== 2'd2 || all_out !== '0) begin
      errs++;
      $display("FAIL rmr_ptr: ptr=%0d outputs=%h, want 2/0", dut.ptr_q, all_out);
    end
  endtask

`ifdef SR_MEM_ARB_STATS_EN
  // One three-cycle transaction for requester 2. stats_clr_i is raised in
  // the response cycle when clr_in_resp is set.
  task automatic run_txn2(input logic clr_in_resp);
    @(negedge clk);
    set_req(2, 1'b0, 16'h0200, 32'h0);
    req_valid_i      = 4'b0100;
    mem_req_ready_i  = 1'b1;
    mem_resp_valid_i = 1'b1;
    resp_ready_i     = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    req_valid_i = 4'b0000;
    stats_clr_i = clr_in_resp;
    @(negedge clk);
    stats_clr_i = 1'b0;
  endtask

  task automatic test_stats();
    do_reset();
    for (int t = 0; t < 3; t++) run_txn2(1'b0);
    #1;
    vecs++;
    if (gnt_cnt_o[2*16 +: 16] !== 16'd3 || gnt_cnt_o[0 +: 16] !== 16'd0) begin
      errs++;
      $display("FAIL stats_count: slice2=%0d slice0=%0d, want 3/0",
               gnt_cnt_o[2*16 +: 16], gnt_cnt_o[0 +: 16]);
    end
    run_txn2(1'b1);
    #1;
    vecs++;
    if (gnt_cnt_o[2*16 +: 16] !== 16'd0) begin
      errs++;
      $display("FAIL stats_clear: slice2=%0d, want 0", gnt_cnt_o[2*16 +: 16]);
    end
    force dut.cnt_q[2] = 16'hFFFF;
    @(negedge clk);
    release dut.cnt_q[2];
    run_txn2(1'b0);
    #1;
    vecs++;
    if (gnt_cnt_o[2*16 +: 16] !== 16'hFFFF) begin
      errs++;
      $display("FAIL stats_saturate: slice2=%h, want ffff", gnt_cnt_o[2*16 +: 16]);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_backpressure();
    test_valid_drop();
    test_wrap_priority();
    test_reset_mid_resp();
`ifdef SR_MEM_ARB_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
